// File: rtl/sys_rst_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// sys_rst_sequencer_pkg
// Shared state codes, reset-cause codes and small helpers for the reset /
// restart sequencer and its request synchroniser.
// ---------------------------------------------------------------------------
package sys_rst_sequencer_pkg;

    // Sequencer states. Encoding 2'd3 is unused and recovers to ST_HOLD.
    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_RUN       = 2'd1,
        ST_TRAP_WAIT = 2'd2
    } state_e;

    // Cause of the most recent system reset, exported on rst_cause.
    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_BTN  = 2'd1,
        CAUSE_SW   = 2'd2,
        CAUSE_TRAP = 2'd3
    } cause_e;

    localparam int          RST_COUNT_W   = 8;
    localparam logic [7:0]  RST_COUNT_MAX = 8'hFF;

    // Saturating increment of the restart counter.
    function automatic logic [RST_COUNT_W-1:0] sat_inc(input logic [RST_COUNT_W-1:0] v);
        logic [RST_COUNT_W-1:0] r;
        if (v == RST_COUNT_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    // Button wins over software when both request in the same cycle.
    function automatic cause_e req_cause(input logic btn);
        cause_e c;
        if (btn) begin
            c = CAUSE_BTN;
        end else begin
            c = CAUSE_SW;
        end
        return c;
    endfunction

endpackage

// File: rtl/sys_rst_sequencer_sync.sv
// ---------------------------------------------------------------------------
// rst_req_sync
// Two-flop synchroniser for an asynchronous request level, followed by a
// rising-edge detector in the destination clock domain. Generic enough to be
// reused for any slow asynchronous input (buttons, straps, external IRQs).
//
// Ports
//   clk      in   destination clock
//   rst      in   synchronous active-high reset, clears all flops
//   async_i  in   asynchronous level
//   level_o  out  synchronised level (2 flops after the pin)
//   rise_o   out  one-cycle pulse on a 0->1 transition of level_o
// ---------------------------------------------------------------------------
module rst_req_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    // Edge is decoded from two registered values, so it is glitch-free and
    // lasts exactly one cycle.
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/sys_rst_sequencer.sv
// ---------------------------------------------------------------------------
// sys_rst_sequencer
// Reset/restart controller sitting between the board clock/reset and the
// SoC core. Holds the core in reset for a programmable time, and restarts it
// on a push-button, a software request, or (after a delay) a CPU trap. The
// last reset cause and a saturating restart count are kept for readout.
//
// Parameters
//   HOLD_W        width of the hold counter
//   HOLD_CYCLES   hold reload; sys_rst stays high HOLD_CYCLES+1 edges after
//                 the last rst edge or restart request
//   DLY_W         width of the trap-restart delay counter
//   TRAP_DELAY    delay reload; the trap wait lasts TRAP_DELAY+1 cycles
//   TRAP_RESTART  1: a trap schedules a restart; 0: a trap is only latched
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-high reset of this block
//   ext_rst_req   in   asynchronous button level
//   sw_rst_req    in   single-cycle software restart pulse
//   trap          in   CPU trap level
//   sys_rst       out  reset to the core, active high
//   running       out  high while the core is released (RUN)
//   trap_latched  out  sticky trap flag, cleared on the next release
//   rst_cause     out  cause of the last reset (POR/BTN/SW/TRAP)
//   rst_count     out  restarts since rst, saturating at 8'hFF
// ---------------------------------------------------------------------------
module sys_rst_sequencer
    import sys_rst_sequencer_pkg::*;
#(
    parameter int              HOLD_W       = 16,
    parameter logic [HOLD_W-1:0] HOLD_CYCLES = 16'hFFFF,
    parameter int              DLY_W        = 10,
    parameter logic [DLY_W-1:0]  TRAP_DELAY  = 10'd1023,
    parameter bit              TRAP_RESTART = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_rst_req,
    input  logic       sw_rst_req,
    input  logic       trap,
    output logic       sys_rst,
    output logic       running,
    output logic       trap_latched,
    output logic [1:0] rst_cause,
    output logic [7:0] rst_count
);

    localparam logic [HOLD_W-1:0] HOLD_ONE = 1;
    localparam logic [DLY_W-1:0]  DLY_ONE  = 1;

    state_e                 state_q;
    logic [HOLD_W-1:0]      hold_cnt_q;
    logic [DLY_W-1:0]       dly_cnt_q;
    logic                   trap_latched_q;
    cause_e                 cause_q;
    logic [RST_COUNT_W-1:0] count_q;

    logic btn_level;
    logic btn_rise;
    logic restart_req;

    rst_req_sync u_btn_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (ext_rst_req),
        .level_o (btn_level),
        .rise_o  (btn_rise)
    );

    assign restart_req = btn_rise | sw_rst_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_HOLD;
            hold_cnt_q     <= HOLD_CYCLES;
            dly_cnt_q      <= '0;
            trap_latched_q <= 1'b0;
            cause_q        <= CAUSE_POR;
            count_q        <= '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    // Requests inside HOLD only extend the hold; they are not
                    // counted as restarts.
                    if (restart_req) begin
                        hold_cnt_q <= HOLD_CYCLES;
                        cause_q    <= req_cause(btn_rise);
                    end else if (btn_level) begin
                        // A held button keeps the core in reset.
                        hold_cnt_q <= HOLD_CYCLES;
                    end else if (hold_cnt_q != '0) begin
                        hold_cnt_q <= hold_cnt_q - HOLD_ONE;
                    end else begin
                        state_q        <= ST_RUN;
                        trap_latched_q <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (restart_req) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= HOLD_CYCLES;
                        cause_q    <= req_cause(btn_rise);
                        count_q    <= sat_inc(count_q);
                    end else if (trap) begin
                        trap_latched_q <= 1'b1;
                        if (TRAP_RESTART) begin
                            state_q   <= ST_TRAP_WAIT;
                            dly_cnt_q <= TRAP_DELAY;
                        end
                    end
                end

                ST_TRAP_WAIT: begin
                    // A button/software request pre-empts the pending trap
                    // restart and takes the cause.
                    if (restart_req) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= HOLD_CYCLES;
                        cause_q    <= req_cause(btn_rise);
                        count_q    <= sat_inc(count_q);
                    end else if (dly_cnt_q == '0) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= HOLD_CYCLES;
                        cause_q    <= CAUSE_TRAP;
                        count_q    <= sat_inc(count_q);
                    end else begin
                        dly_cnt_q <= dly_cnt_q - DLY_ONE;
                    end
                end

                default: begin
                    // Unused encoding: behave like a reset but keep the
                    // restart history.
                    state_q        <= ST_HOLD;
                    hold_cnt_q     <= HOLD_CYCLES;
                    dly_cnt_q      <= '0;
                    trap_latched_q <= 1'b0;
                    cause_q        <= CAUSE_POR;
                end
            endcase
        end
    end

    // The core stays out of reset during the trap wait so it can be inspected;
    // any state other than RUN/TRAP_WAIT (including an illegal one) asserts it.
    assign sys_rst      = (state_q != ST_RUN) && (state_q != ST_TRAP_WAIT);
    assign running      = (state_q == ST_RUN);
    assign trap_latched = trap_latched_q;
    assign rst_cause    = cause_q;
    assign rst_count    = count_q;

endmodule
